// File: rtl/wb_stage.sv
// Writeback stage: registers ALU results or waits for load data, extracts and extends
// the loaded field, drives the regfile write pair, and counts retired instructions.
module wb_stage #(
    parameter int unsigned TIMEOUT_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [4:0]  ex_rd,
    input  logic [63:0] ex_data,
    input  logic        ex_is_load,
    input  logic [2:0]  ex_funct3,
    input  logic [2:0]  ex_addr_lo,
    input  logic        mem_rvalid,
    input  logic [63:0] mem_rdata,
    output logic [4:0]  wb_rd,
    output logic [63:0] wb_out,
    output logic        wb_err,
    output logic [63:0] instret
);

    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [TIMEOUT_W-1:0] TIMER_ONE  = TIMEOUT_W'(1);
    localparam logic [TIMEOUT_W-1:0] TIMER_MAX  = '1;
    localparam logic [TIMEOUT_W-1:0] TIMER_LAST = TIMER_MAX - TIMER_ONE;

    state_t               state;
    logic [TIMEOUT_W-1:0] timer;
    logic [4:0]           ld_rd;
    logic [2:0]           ld_funct3;
    logic [2:0]           ld_addr_lo;

    logic [5:0]  shamt;
    logic [63:0] shifted;
    logic [63:0] ld_data;
    logic        ld_bad;

    assign ex_ready = (state == IDLE);

    // Bit shift is the byte offset times eight; misaligned low address bits are dropped.
    always_comb begin
        shamt = '0;
        case (ld_funct3[1:0])
            2'b00:   shamt = {ld_addr_lo, 3'b000};
            2'b01:   shamt = {ld_addr_lo[2:1], 4'b0000};
            2'b10:   shamt = {ld_addr_lo[2], 5'b00000};
            default: shamt = '0;
        endcase
    end

    assign shifted = mem_rdata >> shamt;

    always_comb begin
        ld_data = '0;
        ld_bad  = 1'b0;
        case (ld_funct3)
            3'b000:  ld_data = {{56{shifted[7]}}, shifted[7:0]};
            3'b001:  ld_data = {{48{shifted[15]}}, shifted[15:0]};
            3'b010:  ld_data = {{32{shifted[31]}}, shifted[31:0]};
            3'b011:  ld_data = shifted;
            3'b100:  ld_data = {56'd0, shifted[7:0]};
            3'b101:  ld_data = {48'd0, shifted[15:0]};
            3'b110:  ld_data = {32'd0, shifted[31:0]};
            default: ld_bad  = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            timer      <= '0;
            ld_rd      <= '0;
            ld_funct3  <= '0;
            ld_addr_lo <= '0;
            wb_rd      <= '0;
            wb_out     <= '0;
            wb_err     <= 1'b0;
            instret    <= '0;
        end else begin
            wb_rd <= '0;
            case (state)
                IDLE: begin
                    if (mem_rvalid) wb_err <= 1'b1;
                    if (ex_valid) begin
                        if (ex_is_load) begin
                            ld_rd      <= ex_rd;
                            ld_funct3  <= ex_funct3;
                            ld_addr_lo <= ex_addr_lo;
                            timer      <= '0;
                            state      <= WAIT;
                        end else begin
                            wb_rd   <= ex_rd;
                            wb_out  <= ex_data;
                            instret <= instret + 64'd1;
                        end
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        state <= IDLE;
                        if (ld_bad) begin
                            wb_err <= 1'b1;
                        end else begin
                            wb_rd   <= ld_rd;
                            wb_out  <= ld_data;
                            instret <= instret + 64'd1;
                        end
                    end else begin
                        timer <= timer + TIMER_ONE;
                        if (timer == TIMER_LAST) begin
                            wb_err <= 1'b1;
                            state  <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: table of ALU/load vectors plus hand-written
// timeout, reset-during-wait and illegal-format sequences.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [4:0]  ex_rd;
    logic [63:0] ex_data;
    logic        ex_is_load;
    logic [2:0]  ex_funct3;
    logic [2:0]  ex_addr_lo;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic [4:0]  wb_rd;
    logic [63:0] wb_out;
    logic        wb_err;
    logic [63:0] instret;

    int unsigned tests = 0;
    int unsigned fails = 0;
    logic [63:0] exp_instret;

    always #5 clk = ~clk;

    wb_stage #(.TIMEOUT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .ex_rd      (ex_rd),
        .ex_data    (ex_data),
        .ex_is_load (ex_is_load),
        .ex_funct3  (ex_funct3),
        .ex_addr_lo (ex_addr_lo),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .wb_rd      (wb_rd),
        .wb_out     (wb_out),
        .wb_err     (wb_err),
        .instret    (instret)
    );

    typedef struct {
        logic        is_load;
        logic [2:0]  funct3;
        logic [2:0]  addr_lo;
        logic [4:0]  rd;
        logic [63:0] data;
        int unsigned delay;
        logic [63:0] exp_out;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic is_load, logic [2:0] funct3, logic [2:0] addr_lo,
                                logic [4:0] rd, logic [63:0] data, int unsigned delay,
                                logic [63:0] exp_out);
        vec_t v;
        v.is_load = is_load; v.funct3 = funct3; v.addr_lo = addr_lo; v.rd = rd;
        v.data = data; v.delay = delay; v.exp_out = exp_out;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_valid = 1'b0; ex_rd = '0; ex_data = '0; ex_is_load = 1'b0;
        ex_funct3 = '0; ex_addr_lo = '0; mem_rvalid = 1'b0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        step();
        step();
        rst_n = 1'b1;
        exp_instret = '0;
    endtask

    int unsigned low_cnt;

    initial begin
        do_reset();

        check("reset_wb_rd",    64'(wb_rd),    64'd0);
        check("reset_wb_out",   wb_out,        64'd0);
        check("reset_ex_ready", 64'(ex_ready), 64'd1);
        check("reset_instret",  instret,       64'd0);
        check("reset_wb_err",   64'(wb_err),   64'd0);

        vecs.push_back(mk(1'b0, 3'b000, 3'd0, 5'd5,  64'h0000_0000_0000_1234, 0, 64'h0000_0000_0000_1234));
        vecs.push_back(mk(1'b1, 3'b000, 3'd3, 5'd7,  64'h0000_0000_8000_0000, 4, 64'hFFFF_FFFF_FFFF_FF80));
        vecs.push_back(mk(1'b1, 3'b100, 3'd3, 5'd8,  64'h0000_0000_8000_0000, 4, 64'h0000_0000_0000_0080));
        vecs.push_back(mk(1'b1, 3'b010, 3'd4, 5'd9,  64'h8765_4321_0000_0000, 1, 64'hFFFF_FFFF_8765_4321));
        vecs.push_back(mk(1'b1, 3'b110, 3'd4, 5'd10, 64'h8765_4321_0000_0000, 2, 64'h0000_0000_8765_4321));
        vecs.push_back(mk(1'b1, 3'b001, 3'd7, 5'd11, 64'h8001_0000_0000_0000, 1, 64'hFFFF_FFFF_FFFF_8001));
        vecs.push_back(mk(1'b1, 3'b101, 3'd2, 5'd12, 64'h0000_0000_ABCD_0000, 3, 64'h0000_0000_0000_ABCD));
        vecs.push_back(mk(1'b1, 3'b011, 3'd5, 5'd13, 64'h0123_4567_89AB_CDEF, 1, 64'h0123_4567_89AB_CDEF));
        vecs.push_back(mk(1'b1, 3'b000, 3'd0, 5'd14, 64'hFFFF_FFFF_FFFF_FF7F, 2, 64'h0000_0000_0000_007F));
        vecs.push_back(mk(1'b1, 3'b010, 3'd7, 5'd15, 64'h1234_5678_0000_0000, 1, 64'h0000_0000_1234_5678));
        vecs.push_back(mk(1'b1, 3'b100, 3'd7, 5'd16, 64'hAB00_0000_0000_0000, 1, 64'h0000_0000_0000_00AB));
        vecs.push_back(mk(1'b1, 3'b011, 3'd0, 5'd0,  64'h5555_AAAA_5555_AAAA, 2, 64'h5555_AAAA_5555_AAAA));
        vecs.push_back(mk(1'b0, 3'b000, 3'd0, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'hFFFF_FFFF_FFFF_FFFF));

        foreach (vecs[i]) begin
            ex_valid   = 1'b1;
            ex_is_load = vecs[i].is_load;
            ex_funct3  = vecs[i].funct3;
            ex_addr_lo = vecs[i].addr_lo;
            ex_rd      = vecs[i].rd;
            ex_data    = vecs[i].is_load ? 64'hDEAD_BEEF_DEAD_BEEF : vecs[i].data;
            step();
            idle_inputs();
            if (!vecs[i].is_load) begin
                exp_instret++;
                check($sformatf("v%0d_alu_rd", i),  64'(wb_rd), 64'(vecs[i].rd));
                check($sformatf("v%0d_alu_out", i), wb_out,     vecs[i].exp_out);
                check($sformatf("v%0d_instret", i), instret,    exp_instret);
                step();
                check($sformatf("v%0d_pulse_rd", i),  64'(wb_rd), 64'd0);
                check($sformatf("v%0d_hold_out", i),  wb_out,     vecs[i].exp_out);
            end else begin
                low_cnt = 0;
                for (int c = 1; c < int'(vecs[i].delay); c++) begin
                    if (!ex_ready) low_cnt++;
                    step();
                end
                if (!ex_ready) low_cnt++;
                mem_rvalid = 1'b1;
                mem_rdata  = vecs[i].data;
                step();
                idle_inputs();
                exp_instret++;
                check($sformatf("v%0d_ready_low", i), 64'(low_cnt),  64'(vecs[i].delay));
                check($sformatf("v%0d_ld_rd", i),     64'(wb_rd),    64'(vecs[i].rd));
                check($sformatf("v%0d_ld_out", i),    wb_out,        vecs[i].exp_out);
                check($sformatf("v%0d_ready", i),     64'(ex_ready), 64'd1);
                check($sformatf("v%0d_instret", i),   instret,       exp_instret);
            end
        end
        check("no_err_after_vectors", 64'(wb_err), 64'd0);

        // Timeout: no rvalid ever arrives.
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_funct3 = 3'b011; ex_rd = 5'd3;
        step();
        idle_inputs();
        low_cnt = 0;
        while (!ex_ready && low_cnt < 400) begin
            low_cnt++;
            step();
        end
        check("timeout_cycles",  64'(low_cnt),  64'd255);
        check("timeout_err",     64'(wb_err),   64'd1);
        check("timeout_no_rd",   64'(wb_rd),    64'd0);
        check("timeout_ready",   64'(ex_ready), 64'd1);
        check("timeout_instret", instret,       exp_instret);

        // Reset while waiting, then a stray rvalid in IDLE.
        do_reset();
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_funct3 = 3'b000; ex_rd = 5'd6;
        step();
        idle_inputs();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("rstwait_ready", 64'(ex_ready), 64'd1);
        check("rstwait_err0",  64'(wb_err),   64'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 64'h0000_0000_0000_00FF;
        step();
        idle_inputs();
        check("rstwait_no_rd",   64'(wb_rd),  64'd0);
        check("rstwait_out",     wb_out,      64'd0);
        check("rstwait_instret", instret,     64'd0);
        check("rstwait_err1",    64'(wb_err), 64'd1);

        // Illegal load format.
        do_reset();
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_funct3 = 3'b111; ex_rd = 5'd4;
        step();
        idle_inputs();
        mem_rvalid = 1'b1;
        mem_rdata  = 64'h1111_2222_3333_4444;
        step();
        idle_inputs();
        check("bad_f3_err",   64'(wb_err),   64'd1);
        check("bad_f3_no_rd", 64'(wb_rd),    64'd0);
        check("bad_f3_ready", 64'(ex_ready), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
